ram_handshake_unit: RTL and testbench
=====================================

# ram_handshake_unit

Byte-addressable 512-byte data/instruction memory that services the control unit's RAM requests over the four-phase MFA/MFC handshake. It sits directly downstream of the control unit: it consumes `ramMFA`, `ramRW`, `ramDataSize` and `ramAddress`, and it produces `ramMFC`, read data for the MDR path, and an alignment-error flag. Access latency is a fixed, parameterised cycle count, so the control unit's wait states are exercised deterministically.

## Interface

Parameters:
- `LATENCY`, default 2: rising edges from request capture to `ramMFC` assertion; legal range 1–15.
- `DEPTH`, default 512: memory size in bytes; the address width is fixed at 9.

Ports:
- `Clk` in 1: single clock, rising-edge active.
- `reset` in 1: asynchronous, active-low reset.
- `ramMFA` in 1: memory function activate (request).
- `ramRW` in 1: 1 = read, 0 = write.
- `ramDataSize` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `ramAddress` in 9: byte address.
- `ramDataIn` in 32: write data, right-justified.
- `ramDataOut` out 32: read data, right-justified and zero-extended.
- `ramMFC` out 1: memory function complete.
- `ramMisaligned` out 1: the completed access was rejected.

## Operation

- State machine has three states: IDLE, WAIT and DONE.
- **IDLE:**
  - On a rising edge with `ramMFA`=1, latch RW, size, address and data.
  - Load the counter with `LATENCY`-1 and go to WAIT.
  - If `LATENCY`=1, go directly to commit (see below).
- **WAIT:**
  - Decrement the counter on each edge.
  - On the edge where the counter equals 0, commit the access, assert `ramMFC` and go to DONE.
- **DONE:**
  - `ramMFC`=1 and `ramDataOut`/`ramMisaligned` are held stable.
  - On an edge with `ramMFA`=0, clear `ramMFC` and `ramMisaligned` and return to IDLE. `ramDataOut` holds its value.
  - A new request is accepted only from IDLE. This enforces the four-phase protocol: MFA↑, MFC↑, MFA↓, MFC↓.
- Inputs are ignored outside the IDLE capture edge. A deasserted `ramMFA` during WAIT does not abort the access.
- **Byte order:** big-endian.
  - Word at address a: mem[a]=D[31:24], mem[a+1]=D[23:16], mem[a+2]=D[15:8], mem[a+3]=D[7:0].
  - Halfword at address a: mem[a]=D[15:8], mem[a+1]=D[7:0].
  - Byte: mem[a]=D[7:0].
- **Reads:**
  - Byte and halfword data are zero-extended into `ramDataOut`.
  - Sign extension is the datapath's job.
- **Alignment rules:**
  - A halfword requires address[0]=0.
  - A word requires address[1:0]=00.
  - Size 11 is always an error.
- **On error:**
  - Memory is unchanged.
  - `ramDataOut`=0.
  - `ramMisaligned`=1 is asserted together with `ramMFC`, so the handshake still completes.
- Memory is not initialised by reset. Contents are undefined until written; benches may preload them via hierarchical `$readmemb`.

## Timing

- **Reset** (asynchronous assertion, `reset`=0):
  - State goes to IDLE.
  - `ramMFC`=0, `ramMisaligned`=0, `ramDataOut`=0 immediately.
  - Counter is cleared.
- **Reset during WAIT:** the access is aborted and no write occurs.
- **Reset during DONE:** a write has already been committed and remains in memory.
- **Latency:** `ramMFC` rises exactly `LATENCY` rising edges after the edge that captured `ramMFA`=1.
- **Read data timing:** read data is valid at the same edge `ramMFC` rises.
- **Write commit:** memory is written on that same edge.
- **Deassertion:** `ramMFC` falls on the first edge at which `ramMFA`=0 is sampled in DONE.
- **Back-to-back requests:** if `ramMFA` is reasserted on the edge right after MFC falls, it is captured from IDLE. The minimum period per access is `LATENCY`+2 edges.
- **Simultaneous events:** if reset is released on the same edge that `ramMFA`=1 is sampled, the request is captured only if `reset` was already high before that edge.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- **Word write/read, `LATENCY`=2:**
  - Write 0xDEADBEEF to address 0x004.
  - Required: MFC rises 2 edges after capture; MFC falls one edge after MFA drops.
  - Read word 0x004 → `ramDataOut`=0xDEADBEEF. Read byte 0x005 → 0x000000AD.
- **Halfword/byte merge:**
  - Preload word 0x008=0x00000000.
  - Write half 0x1234 to address 0x00A, then byte 0x56 to address 0x008.
  - Required: word read of 0x008 returns 0x56001234.
- **Misalignment:**
  - Word write of 0xFFFFFFFF to address 0x006 → MFC=1, `ramMisaligned`=1, and a word read of 0x004 is unchanged.
  - Size 11 read → `ramMisaligned`=1, `ramDataOut`=0.
- **Handshake hold:**
  - Keep MFA=1 for 10 cycles after MFC rises.
  - Required: MFC stays 1 and data stays stable; a second request is not accepted until MFC has dropped.
- **Reset mid-WAIT:**
  - Start a word write of 0xCAFEF00D to address 0x010 with `LATENCY`=4, and pulse `reset`=0 after 2 edges.
  - Required: outputs clear immediately; a subsequent read of 0x010 returns the prior value.
- **`LATENCY`=1 back-to-back:**
  - Issue three consecutive reads with MFA reasserted immediately after MFC falls.
  - Required: each read's MFC rises one edge after its capture, and the sequence completes in 9 edges.

Source files
------------

// File: rtl/ram_handshake_unit.sv
// Byte-addressable big-endian RAM behind a four-phase MFA/MFC handshake.
// Fixed-latency access; misaligned or reserved-size requests complete with ramMisaligned set.
module ram_handshake_unit #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        ramMFA,
  input  logic        ramRW,
  input  logic [1:0]  ramDataSize,
  input  logic [8:0]  ramAddress,
  input  logic [31:0] ramDataIn,
  output logic [31:0] ramDataOut,
  output logic        ramMFC,
  output logic        ramMisaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mfc_q, mfc_d;
  logic        mis_q, mis_d;
  logic [31:0] dout_q, dout_d;

  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [7:0]  mem_q [DEPTH];

  logic [8:0]  addr_p1, addr_p2, addr_p3;
  logic        commit;
  logic        acc_err;
  logic        wr_en;
  logic [31:0] rd_data;

  assign addr_p1 = addr_q + 9'd1;
  assign addr_p2 = addr_q + 9'd2;
  assign addr_p3 = addr_q + 9'd3;

  // The access takes effect on the edge where the wait counter has run out.
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign wr_en  = commit && !rw_q && !acc_err;

  always_comb begin
    acc_err = 1'b0;
    case (size_q)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = addr_q[0];
      2'b10:   acc_err = (addr_q[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (size_q)
      2'b00:   rd_data = {24'd0, mem_q[addr_q]};
      2'b01:   rd_data = {16'd0, mem_q[addr_q], mem_q[addr_p1]};
      2'b10:   rd_data = {mem_q[addr_q], mem_q[addr_p1], mem_q[addr_p2], mem_q[addr_p3]};
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mfc_d   = mfc_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (ramMFA) begin
          rw_d    = ramRW;
          size_d  = ramDataSize;
          addr_d  = ramAddress;
          wdata_d = ramDataIn;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          mfc_d   = 1'b1;
          mis_d   = acc_err;
          if (acc_err) begin
            dout_d = '0;
          end else if (rw_q) begin
            dout_d = rd_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // Hold the completion until the requester withdraws MFA.
        if (!ramMFA) begin
          mfc_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mfc_q   <= 1'b0;
      mis_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
    end
  end

  // Request fields carry no reset: they are only consumed after a capture.
  always_ff @(posedge Clk) begin
    rw_q    <= rw_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      case (size_q)
        2'b00: mem_q[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem_q[addr_q]  <= wdata_q[15:8];
          mem_q[addr_p1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem_q[addr_q]  <= wdata_q[31:24];
          mem_q[addr_p1] <= wdata_q[23:16];
          mem_q[addr_p2] <= wdata_q[15:8];
          mem_q[addr_p3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign ramDataOut    = dout_q;
  assign ramMFC        = mfc_q;
  assign ramMisaligned = mis_q;

endmodule

// File: tb/tb_ram_handshake_unit.sv
// Bench for ram_handshake_unit: three instances (latency 2, 4, 1) checked against
// a byte-array memory model driven by directed and random handshake transactions.
module tb_ram_handshake_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  mfa;
  logic [2:0]  rst_n;
  logic        rw;
  logic [1:0]  size;
  logic [8:0]  addr;
  logic [31:0] din;
  logic [31:0] dout [3];
  logic [2:0]  mfc;
  logic [2:0]  mis;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int cap_edge = 0;
  int fall_edge = 0;

  always @(posedge clk) edge_cnt++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_handshake_unit #(
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 4 : 1)),
      .DEPTH  (512)
    ) u_dut (
      .Clk          (clk),
      .reset        (rst_n[g]),
      .ramMFA       (mfa[g]),
      .ramRW        (rw),
      .ramDataSize  (size),
      .ramAddress   (addr),
      .ramDataIn    (din),
      .ramDataOut   (dout[g]),
      .ramMFC       (mfc[g]),
      .ramMisaligned(mis[g])
    );
  end

  // Reference model: one byte array per instance plus the last visible read data.
  logic [7:0]  mdl   [3][512];
  logic [31:0] pdout [3];

  function automatic int lat(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 4 : 1);
  endfunction

  function automatic logic is_err(input logic [1:0] s, input logic [8:0] a);
    return (s == 2'd3) || ((s == 2'd1) && (a % 2 != 0)) || ((s == 2'd2) && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] mdl_read(input int u, input logic [1:0] s, input logic [8:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (s == 2'd0) begin
      r = 32'(mdl[u][a]);
    end else if (s == 2'd1) begin
      r = 32'(mdl[u][a]) * 256 + 32'(mdl[u][a + 9'd1]);
    end else if (s == 2'd2) begin
      for (int i = 0; i < 4; i++) r = r * 256 + 32'(mdl[u][a + 9'(i)]);
    end
    return r;
  endfunction

  function automatic void mdl_write(input int u, input logic [1:0] s, input logic [8:0] a,
                                    input logic [31:0] d);
    if (s == 2'd0) begin
      mdl[u][a] = d[7:0];
    end else if (s == 2'd1) begin
      mdl[u][a]         = 8'(d / 256);
      mdl[u][a + 9'd1]  = 8'(d);
    end else if (s == 2'd2) begin
      for (int i = 0; i < 4; i++) mdl[u][a + 9'(i)] = 8'(d >> (8 * (3 - i)));
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full four-phase transaction on instance u, holding MFA for 'hold' extra cycles.
  task automatic access(input int u, input logic r, input logic [1:0] s, input logic [8:0] a,
                        input logic [31:0] d, input int hold, output logic [31:0] got);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    exp_e = is_err(s, a);
    if (exp_e) exp_d = 32'd0;
    else if (r) exp_d = mdl_read(u, s, a);
    else begin
      exp_d = pdout[u];
      mdl_write(u, s, a, d);
    end
    pdout[u] = exp_d;

    @(negedge clk);
    rw = r; size = s; addr = a; din = d; mfa[u] = 1'b1;
    @(posedge clk); #1;
    cap_edge = edge_cnt;
    check("mfc_low_at_capture", 32'(mfc[u]), 32'd0);
    n = 0;
    while (!mfc[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat(u));
    check("misaligned", 32'(mis[u]), 32'(exp_e));
    check("dout", dout[u], exp_d);
    got = dout[u];

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rw = 1'($urandom); size = 2'($urandom); addr = 9'($urandom); din = $urandom;
      @(posedge clk); #1;
      check("hold_mfc", 32'(mfc[u]), 32'd1);
      check("hold_dout", dout[u], exp_d);
      check("hold_mis", 32'(mis[u]), 32'(exp_e));
    end

    @(negedge clk);
    mfa[u] = 1'b0;
    rw = 1'($urandom); size = 2'($urandom); addr = 9'($urandom); din = $urandom;
    @(posedge clk); #1;
    fall_edge = edge_cnt;
    check("mfc_fall", 32'(mfc[u]), 32'd0);
    check("mis_fall", 32'(mis[u]), 32'd0);
    check("dout_keep", dout[u], exp_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic        r;
    logic [1:0]  s;
    logic [8:0]  a;
    int          n;
    int          first_cap;

    rst_n = 3'b000; mfa = 3'b000; rw = 1'b0; size = 2'd0; addr = 9'd0; din = 32'd0;
    for (int u = 0; u < 3; u++) pdout[u] = 32'd0;
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_dout", dout[u], 32'd0);
      check("rst_mfc", 32'(mfc[u]), 32'd0);
      check("rst_mis", 32'(mis[u]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 3'b111;

    // Fill instance 0 so every later read has defined contents.
    for (int i = 0; i < 128; i++) access(0, 1'b0, 2'd2, 9'(i * 4), $urandom, 0, got);

    // Word write/read and byte extract.
    access(0, 1'b0, 2'd2, 9'h004, 32'hDEADBEEF, 0, got);
    access(0, 1'b1, 2'd2, 9'h004, 32'd0, 0, got);
    check("word_read", got, 32'hDEADBEEF);
    access(0, 1'b1, 2'd0, 9'h005, 32'd0, 0, got);
    check("byte_read", got, 32'h000000AD);

    // Halfword and byte merged into a zeroed word.
    access(0, 1'b0, 2'd2, 9'h008, 32'h00000000, 0, got);
    access(0, 1'b0, 2'd1, 9'h00A, 32'h00001234, 0, got);
    access(0, 1'b0, 2'd0, 9'h008, 32'h00000056, 0, got);
    access(0, 1'b1, 2'd2, 9'h008, 32'd0, 0, got);
    check("merge_read", got, 32'h56001234);

    // Rejected accesses.
    access(0, 1'b0, 2'd2, 9'h006, 32'hFFFFFFFF, 0, got);
    check("misaligned_write_dout", got, 32'd0);
    access(0, 1'b1, 2'd2, 9'h004, 32'd0, 0, got);
    check("after_misaligned", got, 32'hDEADBEEF);
    access(0, 1'b1, 2'd3, 9'h004, 32'd0, 0, got);
    check("size11_dout", got, 32'd0);
    access(0, 1'b1, 2'd1, 9'h003, 32'd0, 0, got);
    check("half_misaligned_dout", got, 32'd0);

    // Long MFA hold with garbage on the inputs, then a fresh request.
    access(0, 1'b1, 2'd2, 9'h004, 32'd0, 10, got);
    check("hold_read", got, 32'hDEADBEEF);
    access(0, 1'b1, 2'd1, 9'h00A, 32'd0, 0, got);
    check("after_hold_read", got, 32'h00001234);

    // Randomised traffic against the model.
    for (int i = 0; i < 80; i++) begin
      r = 1'($urandom);
      s = 2'($urandom);
      a = 9'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      access(0, r, s, a, $urandom, int'($urandom_range(0, 3)), got);
    end

    // Reset in the middle of the wait period on the latency-4 instance.
    access(1, 1'b0, 2'd2, 9'h010, 32'h11223344, 0, got);
    access(1, 1'b1, 2'd2, 9'h010, 32'd0, 0, got);
    check("l4_prior", got, 32'h11223344);
    @(negedge clk);
    rw = 1'b0; size = 2'd2; addr = 9'h010; din = 32'hCAFEF00D; mfa[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    check("wait_rst_mfc", 32'(mfc[1]), 32'd0);
    check("wait_rst_mis", 32'(mis[1]), 32'd0);
    check("wait_rst_dout", dout[1], 32'd0);
    pdout[1] = 32'd0;
    @(negedge clk); mfa[1] = 1'b0;
    @(negedge clk); rst_n[1] = 1'b1;
    access(1, 1'b1, 2'd2, 9'h010, 32'd0, 0, got);
    check("wait_rst_no_write", got, 32'h11223344);

    // Reset while in DONE keeps the committed write.
    @(negedge clk);
    rw = 1'b0; size = 2'd1; addr = 9'h020; din = 32'h0000A5A5; mfa[1] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!mfc[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_latency", n, 4);
    #2 rst_n[1] = 1'b0;
    #1;
    check("done_rst_mfc", 32'(mfc[1]), 32'd0);
    mdl_write(1, 2'd1, 9'h020, 32'h0000A5A5);
    pdout[1] = 32'd0;
    @(negedge clk); mfa[1] = 1'b0;
    @(negedge clk); rst_n[1] = 1'b1;
    access(1, 1'b1, 2'd1, 9'h020, 32'd0, 0, got);
    check("done_rst_kept", got, 32'h0000A5A5);

    // Latency-1 back-to-back reads.
    access(2, 1'b0, 2'd2, 9'h000, 32'h01020304, 0, got);
    access(2, 1'b0, 2'd2, 9'h004, 32'hA0B0C0D0, 0, got);
    access(2, 1'b0, 2'd2, 9'h008, 32'h55AA33CC, 0, got);
    access(2, 1'b1, 2'd2, 9'h000, 32'd0, 0, got);
    first_cap = cap_edge;
    check("b2b_read0", got, 32'h01020304);
    access(2, 1'b1, 2'd0, 9'h005, 32'd0, 0, got);
    check("b2b_read1", got, 32'h000000B0);
    access(2, 1'b1, 2'd1, 9'h00A, 32'd0, 0, got);
    check("b2b_read2", got, 32'h000033CC);
    check("b2b_edges", fall_edge - first_cap + 1, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
